// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to NUM_CDB_PORTS of NUM_REQ FU results per cycle onto registered bus slots.
// Optional build macro CDB_AGE_PRIORITY_EN selects oldest-ROB-entry-first instead of round-robin.

module cdb_slot #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         vld_i,
  input  logic [W-1:0] pld_i,
  output logic         vld_o,
  output logic [W-1:0] pld_o
);
  logic         vld_q;
  logic [W-1:0] pld_q;

  // Idle slots keep their last payload; only the valid bit is meaningful.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vld_q <= 1'b0;
      pld_q <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) pld_q <= pld_i;
    end
  end

  assign vld_o = vld_q;
  assign pld_o = pld_q;
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_CDB_PORTS  = 2,
  parameter int TAG_WIDTH      = 5,
  parameter int ROB_SIZE       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                          clk_i,
  input  logic                                          reset_ni,
  input  logic                                          flush_i,
  input  logic [NUM_REQ-1:0]                            req_valid_i,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]             req_tag_i,
  input  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0]        req_reg_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]            req_value_i,
  output logic [NUM_REQ-1:0]                            req_ready_o,
  input  logic [TAG_WIDTH-1:0]                          rob_head_tag_i,
  output logic [NUM_CDB_PORTS-1:0]                      cdb_valid_o,
  output logic [NUM_CDB_PORTS-1:0][TAG_WIDTH-1:0]       cdb_tag_o,
  output logic [NUM_CDB_PORTS-1:0][REG_ADDR_WIDTH-1:0]  cdb_reg_addr_o,
  output logic [NUM_CDB_PORTS-1:0][DATA_WIDTH-1:0]      cdb_value_o,
  output logic [15:0]                                   busy_cycles_o
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PLD_W = TAG_WIDTH + REG_ADDR_WIDTH + DATA_WIDTH;

  logic [PTR_W-1:0]                          rr_q, rr_d;
  logic [15:0]                               busy_q, busy_d;
  logic [NUM_REQ-1:0]                        grant;
  logic [NUM_CDB_PORTS-1:0]                  slot_vld;
  logic [NUM_CDB_PORTS-1:0][PTR_W-1:0]       slot_sel;
  logic [NUM_CDB_PORTS-1:0][PLD_W-1:0]       slot_pld, slot_pld_q;
  int                                        last;

`ifdef CDB_AGE_PRIORITY_EN
  // Oldest ROB entry first; strict compare keeps the lower index on equal ages.
  always_comb begin : p_sel
    int           age [NUM_REQ];
    int           best;
    int           best_age;
    logic [NUM_REQ-1:0] taken;
    grant    = '0;
    slot_vld = '0;
    slot_sel = '0;
    last     = int'(rr_q);
    taken    = '0;
    best     = -1;
    best_age = ROB_SIZE;
    for (int i = 0; i < NUM_REQ; i++)
      age[i] = (int'(req_tag_i[i]) - int'(rob_head_tag_i) + ROB_SIZE) % ROB_SIZE;
    for (int k = 0; k < NUM_CDB_PORTS; k++) begin
      best     = -1;
      best_age = ROB_SIZE;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid_i[i] && !taken[i] && age[i] < best_age) begin
          best     = i;
          best_age = age[i];
        end
      for (int i = 0; i < NUM_REQ; i++)
        if (i == best) begin
          taken[i]    = 1'b1;
          slot_vld[k] = 1'b1;
          slot_sel[k] = PTR_W'(i);
          last        = i;
        end
    end
    grant = taken;
    if (flush_i || !reset_ni) begin
      grant    = '0;
      slot_vld = '0;
    end
  end
`else
  logic unused_head;
  assign unused_head = ^rob_head_tag_i;

  // Scan from rr_q with wrap; the k-th valid requester found lands on port k.
  always_comb begin : p_sel
    int cnt;
    int idx;
    grant    = '0;
    slot_vld = '0;
    slot_sel = '0;
    last     = int'(rr_q);
    cnt      = 0;
    idx      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = int'(rr_q) + j;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++)
        if (i == idx && req_valid_i[i] && cnt < NUM_CDB_PORTS) begin
          grant[i] = 1'b1;
          last     = i;
          for (int k = 0; k < NUM_CDB_PORTS; k++)
            if (k == cnt) begin
              slot_vld[k] = 1'b1;
              slot_sel[k] = PTR_W'(i);
            end
          cnt = cnt + 1;
        end
    end
    if (flush_i || !reset_ni) begin
      grant    = '0;
      slot_vld = '0;
    end
  end
`endif

  always_comb begin : p_next
    int pop;
    int ng;
    pop = 0;
    ng  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop = pop + int'(req_valid_i[i]);
      ng  = ng + int'(grant[i]);
    end
    rr_d = rr_q;
    if (|grant) rr_d = (last == NUM_REQ - 1) ? '0 : PTR_W'(last + 1);
    busy_d = busy_q;
    if (!flush_i && pop > ng && busy_q != 16'hFFFF) busy_d = busy_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_q   <= '0;
      busy_q <= '0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_CDB_PORTS; k++) begin : g_slot
    assign slot_pld[k] = {req_tag_i[slot_sel[k]], req_reg_addr_i[slot_sel[k]],
                          req_value_i[slot_sel[k]]};
    cdb_slot #(.W(PLD_W)) u_slot (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .vld_i    (slot_vld[k]),
      .pld_i    (slot_pld[k]),
      .vld_o    (cdb_valid_o[k]),
      .pld_o    (slot_pld_q[k])
    );
    assign {cdb_tag_o[k], cdb_reg_addr_o[k], cdb_value_o[k]} = slot_pld_q[k];
  end

  assign req_ready_o   = grant;
  assign busy_cycles_o = busy_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts queued at grant time, checked one cycle later.

module tb_cdb_arbiter;
  logic                  clk, reset_n, flush;
  logic [3:0]            req_valid, req_ready;
  logic [3:0][4:0]       req_tag, req_reg;
  logic [3:0][31:0]      req_value;
  logic [4:0]            rob_head;
  logic [1:0]            cdb_valid;
  logic [1:0][4:0]       cdb_tag, cdb_reg;
  logic [1:0][31:0]      cdb_value;
  logic [15:0]           busy;

  typedef struct {
    logic [1:0]       v;
    logic [1:0][4:0]  tag;
    logic [1:0][4:0]  rg;
    logic [1:0][31:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_busy = 0;

  cdb_arbiter dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_tag_i      (req_tag),
    .req_reg_addr_i (req_reg),
    .req_value_i    (req_value),
    .req_ready_o    (req_ready),
    .rob_head_tag_i (rob_head),
    .cdb_valid_o    (cdb_valid),
    .cdb_tag_o      (cdb_tag),
    .cdb_reg_addr_o (cdb_reg),
    .cdb_value_o    (cdb_value),
    .busy_cycles_o  (busy)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  // One cycle: drive at negedge, check ready, queue expected broadcast, check after posedge.
  task automatic step(input string nm, input logic [3:0] v, input logic f,
                      input logic [3:0] er, input int p0, input int p1);
    exp_t e;
    int   ps[2];
    @(negedge clk);
    req_valid = v;
    flush     = f;
    #1;
    chk({nm, ".ready"}, 64'(req_ready), 64'(er));
    ps[0] = p0;
    ps[1] = p1;
    e.v = '0; e.tag = '0; e.rg = '0; e.val = '0;
    for (int k = 0; k < 2; k++)
      if (ps[k] >= 0) begin
        e.v[k]   = 1'b1;
        e.tag[k] = req_tag[ps[k]];
        e.rg[k]  = req_reg[ps[k]];
        e.val[k] = req_value[ps[k]];
      end
    q.push_back(e);
    if (!f && $countones(v) > 2) exp_busy++;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({nm, ".queue"}, 64'd0, 64'd1);
    end else begin
      e = q.pop_front();
      chk({nm, ".cdb_valid"}, 64'(cdb_valid), 64'(e.v));
      for (int k = 0; k < 2; k++)
        if (e.v[k]) begin
          chk($sformatf("%s.tag%0d", nm, k), 64'(cdb_tag[k]), 64'(e.tag[k]));
          chk($sformatf("%s.reg%0d", nm, k), 64'(cdb_reg[k]), 64'(e.rg[k]));
          chk($sformatf("%s.val%0d", nm, k), 64'(cdb_value[k]), 64'(e.val[k]));
        end
    end
    chk({nm, ".busy"}, 64'(busy), 64'(exp_busy));
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    rob_head  = '0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_tag[i]   = 5'(10 + i);
      req_reg[i]   = 5'(20 + i);
      req_value[i] = 32'hA000_0000 + 32'(i);
    end
    #2;
    chk("rst.ready", 64'(req_ready), 64'd0);
    chk("rst.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.tag", 64'(cdb_tag), 64'd0);
    #30;
    chk("rst_hold.ready", 64'(req_ready), 64'd0);
    chk("rst_hold.cdb_valid", 64'(cdb_valid), 64'd0);
    #2;
    req_valid = 4'b0000;
    #1;
    reset_n = 1'b1;

    step("t1_a", 4'b1111, 1'b0, 4'b0011, 0, 1);
    step("t1_b", 4'b1100, 1'b0, 4'b1100, 2, 3);
    step("t3_a", 4'b1111, 1'b0, 4'b0011, 0, 1);
    step("t3_b", 4'b1100, 1'b0, 4'b1100, 2, 3);

    req_tag[2] = 5'd2; req_reg[2] = 5'd7; req_value[2] = 32'h1234;
    step("t2", 4'b0100, 1'b0, 4'b0100, 2, -1);
    step("idle", 4'b0000, 1'b0, 4'b0000, -1, -1);
    step("t4_wrap", 4'b1001, 1'b0, 4'b1001, 3, 0);
    step("t5_n", 4'b0010, 1'b0, 4'b0010, 1, -1);
    step("t5_flush", 4'b0100, 1'b1, 4'b0000, -1, -1);
    step("flush_all", 4'b1111, 1'b1, 4'b0000, -1, -1);
    step("t5_after", 4'b0100, 1'b0, 4'b0100, 2, -1);

    rob_head = 5'd30;
    req_tag[0] = 5'd3; req_tag[1] = 5'd31; req_tag[2] = 5'd30;
`ifdef CDB_AGE_PRIORITY_EN
    step("t6_age_a", 4'b0111, 1'b0, 4'b0110, 2, 1);
    step("t6_age_b", 4'b0001, 1'b0, 4'b0001, 0, -1);
`else
    step("t6_rr_a", 4'b0111, 1'b0, 4'b0011, 0, 1);
    step("t6_rr_b", 4'b0100, 1'b0, 4'b0100, 2, -1);
`endif

    step("pre_rst", 4'b0001, 1'b0, 4'b0001, 0, -1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst.ready", 64'(req_ready), 64'd0);
    chk("async_rst.busy", 64'(busy), 64'd0);
    chk("async_rst.value", 64'(cdb_value), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates result broadcasts from NUM_REQ functional units onto NUM_CDB_PORTS common-data-bus slots, which are the slots the ROB and reservation stations snoop. It sits between the FU result stages and the CDB_IF master side. Each cycle it grants up to NUM_CDB_PORTS pending requesters and drives their tag, destination register and value onto the bus one cycle later from registered outputs. A rotating pointer gives fair round-robin priority, and a flush discards in-flight broadcasts.

Parameters:
NUM_REQ, 4, number of requesting functional units (equals `NUM_OF_FU).
NUM_CDB_PORTS, 2, broadcast slots per cycle; must be between 1 and NUM_REQ.
TAG_WIDTH, 5, ROB tag width (equals `ROB_SIZE_WIDTH).
ROB_SIZE, 32, number of ROB entries; used for age arithmetic.
REG_ADDR_WIDTH, 5, architectural register address width.
DATA_WIDTH, 32, result value width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
flush  in  1  pipeline flush; synchronous, takes precedence over grants.
req_valid  in  NUM_REQ  FU i has a result pending.
req_tag  in  NUM_REQ*TAG_WIDTH  ROB tag of FU i; slice i holds FU i.
req_reg_addr  in  NUM_REQ*REG_ADDR_WIDTH  destination architectural register of FU i.
req_value  in  NUM_REQ*DATA_WIDTH  result value of FU i.
req_ready  out  NUM_REQ  combinational grant; FU i's payload is accepted this cycle.
rob_head_tag  in  TAG_WIDTH  ROB head tag; used only when CDB_AGE_PRIORITY_EN is defined.
cdb_valid  out  NUM_CDB_PORTS  registered broadcast valid per port.
cdb_tag  out  NUM_CDB_PORTS*TAG_WIDTH  registered broadcast tag.
cdb_reg_addr  out  NUM_CDB_PORTS*REG_ADDR_WIDTH  registered broadcast destination register.
cdb_value  out  NUM_CDB_PORTS*DATA_WIDTH  registered broadcast value.
busy_cycles  out  16  saturating count of cycles in which at least one requester was left waiting.

Behaviour:
- Reset (reset=0, asynchronous):
  - cdb_valid=0, cdb_tag=0, cdb_reg_addr=0, cdb_value=0.
  - rr_ptr=0, busy_cycles=0.
  - req_ready=0 while reset is asserted.
- Handshake:
  - An FU holds req_valid and its payload stable until it sees req_ready=1.
  - req_ready[i]=1 only if req_valid[i]=1.
  - A transfer happens on a rising edge where valid and ready are both 1.
  - req_ready is combinational from req_valid, rr_ptr and flush; it never depends on cdb_* outputs.
- Grant selection (round-robin, default):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Grant the first min(NUM_CDB_PORTS, popcount(req_valid)) valid requesters.
  - The k-th winner in scan order is mapped to CDB port k; ports with no winner carry cdb_valid=0 the next cycle.
- Latency:
  - A payload granted in cycle N appears on cdb_* in cycle N+1 for exactly one cycle.
  - cdb_valid deasserts in N+2 unless that port receives a new grant.
  - Outputs of idle ports hold their previous tag/reg/value; only cdb_valid=0 matters for them.
- Pointer update:
  - If any grant occurs, rr_ptr <= (index of last winner + 1) mod NUM_REQ.
  - If there are no grants, rr_ptr holds.
  - Wrap-around: a winner at NUM_REQ-1 sets rr_ptr to 0.
- Full contention:
  - With all NUM_REQ valid, every requester is granted within ceil(NUM_REQ/NUM_CDB_PORTS) cycles.
  - No requester waits more than that bound.
- Flush:
  - flush=1 forces req_ready=0 that cycle.
  - Next edge: cdb_valid <= 0; rr_ptr holds.
  - FUs drop their pending results on flush (FU responsibility); the arbiter keeps no internal queue.
- busy_cycles:
  - Increments on cycles where popcount(req_valid) > number of grants and flush=0.
  - Saturates at 16'hFFFF.
- Reset mid-operation clears the registered broadcast immediately (asynchronous); no partial broadcast survives.
- NUM_CDB_PORTS=NUM_REQ degenerates to grant-all: req_ready = req_valid when flush=0.

Optional Feature:
CDB_AGE_PRIORITY_EN
- Defined:
  - Priority is by ROB age: age_i = (req_tag_i - rob_head_tag) mod ROB_SIZE; smaller age wins.
  - Equal ages are broken by lower index.
  - Winners are mapped to ports in ascending age.
  - rr_ptr is still maintained but unused for selection.
  - Favours commit-critical results.
- Undefined:
  - Pure round-robin as above.
  - The rob_head_tag port exists but is ignored.

Test Plan:
1. Reset held 0 for 35 ns with req_valid=4'b1111 -> req_ready=0, cdb_valid=0, busy_cycles=0; after release the first grants go to FU0 and FU1 (ports 0 and 1).
2. req_valid=4'b0100, tag=2, reg=7, value=0x1234 for one cycle -> req_ready[2]=1 same cycle; next cycle cdb_valid=2'b01, cdb_tag[0]=2, cdb_reg_addr[0]=7, cdb_value[0]=0x1234; rr_ptr=3.
3. All four FUs valid, held until ready -> cycle 0 grants FU0/FU1, cycle 1 grants FU2/FU3; busy_cycles=1; rr_ptr wraps to 0.
4. FU3 and FU0 valid with rr_ptr=3 -> FU3 on port 0, FU0 on port 1; rr_ptr becomes 1.
5. Grant FU1 in cycle N, flush=1 in cycle N+1 with FU2 valid -> req_ready[2]=0 in N+1; cdb_valid=0 in N+2.
6. With CDB_AGE_PRIORITY_EN defined, rob_head_tag=30, tags FU0=3, FU1=31, FU2=30 -> FU2 granted on port 0, FU1 on port 1; FU0 waits one cycle.
